// File: rtl/codec_pkg.sv
// Shared constants and helpers for the CS4272 slave-mode codec interface.
// One frame is 1024 system clocks: right half first, then left half, 16 SCLK periods each.
package codec_pkg;

    localparam int CNT_W = 10;
    localparam int SMP_W = 16;

    localparam logic [CNT_W-1:0] CNT_READY   = 10'd511;
    localparam logic [CNT_W-1:0] CNT_LFT_END = 10'd1023;
    localparam logic [4:0]       SCLK_SAMPLE = 5'd17;
    localparam logic [4:0]       SCLK_DRIVE  = 5'd31;

    // Position of the current clk within one SCLK period
    function automatic logic [4:0] sclk_phase(input logic [CNT_W-1:0] cnt);
        return cnt[4:0];
    endfunction

    // Shift one serial bit into the LSB end of a sample word
    function automatic logic [SMP_W-1:0] shift_in(input logic [SMP_W-1:0] sh, input logic b);
        return {sh[SMP_W-2:0], b};
    endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Frame counter and derived codec clocks. MCLK, SCLK and LRCLK are flops loaded
// from the next counter value so that each always equals its counter bit.
module codec_clk_gen
    import codec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic             MCLK,
    output logic             SCLK,
    output logic             LRCLK
);

    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + 10'd1;

    // Free-running frame counter with registered clock taps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            MCLK  <= 1'b0;
            SCLK  <= 1'b0;
            LRCLK <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            MCLK  <= cnt_nxt[1];
            SCLK  <= cnt_nxt[4];
            LRCLK <= cnt_nxt[9];
        end
    end

endmodule

// File: rtl/codec_intf.sv
// FPGA-side master for a CS4272 in slave, left-justified, 16-bit mode.
// Serializes the playback pair onto SDin and collects SDout into the record pair.
module codec_intf
    import codec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic             MCLK,
    output logic             SCLK,
    output logic             LRCLK,
    output logic             SDin,
    input  logic             SDout,
    input  logic [SMP_W-1:0] lft_out,
    input  logic [SMP_W-1:0] rht_out,
    output logic             ready,
    output logic [SMP_W-1:0] lft_in,
    output logic [SMP_W-1:0] rht_in,
    output logic             valid
);

    logic [CNT_W-1:0] cnt;
    logic [SMP_W-1:0] tx_sh;
    logic [SMP_W-1:0] rht_hold;
    logic [SMP_W-1:0] rx_sh;
    logic [SMP_W-1:0] lft_stage;
    logic             sdo_q;
    logic             primed;
    logic             ready_cyc;
    logic             lft_end;

    codec_clk_gen u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .MCLK  (MCLK),
        .SCLK  (SCLK),
        .LRCLK (LRCLK)
    );

    assign ready_cyc = (cnt == CNT_READY);
    assign lft_end   = (cnt == CNT_LFT_END);
    assign SDin      = tx_sh[SMP_W-1];

    // Handshake strobes, registered one cycle ahead so they line up with the decode cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
            valid <= 1'b0;
        end else begin
            ready <= (cnt == CNT_READY - 10'd1);
            valid <= ready_cyc && primed;
        end
    end

    // Playback: capture the pair at the end of ready, then shift MSB first on SCLK falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh    <= '0;
            rht_hold <= '0;
        end else if (ready_cyc) begin
            tx_sh    <= lft_out;
            rht_hold <= rht_out;
        end else if (lft_end) begin
            tx_sh    <= rht_hold;
        end else if (sclk_phase(cnt) == SCLK_DRIVE) begin
            tx_sh    <= {tx_sh[SMP_W-2:0], 1'b0};
        end
    end

    // Record: sample SDout just after each SCLK rise and hand off whole words per half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdo_q     <= 1'b0;
            rx_sh     <= '0;
            lft_stage <= '0;
            primed    <= 1'b0;
            lft_in    <= '0;
            rht_in    <= '0;
        end else begin
            sdo_q <= SDout;
            if (sclk_phase(cnt) == SCLK_SAMPLE) begin
                rx_sh <= shift_in(rx_sh, sdo_q);
            end
            if (lft_end) begin
                lft_stage <= rx_sh;
                primed    <= 1'b1;
            end
            if (ready_cyc) begin
                lft_in <= lft_stage;
                rht_in <= rx_sh;
            end
        end
    end

endmodule
